// File: rtl/btb_update_ctrl_if.sv
// Request/response bundle between the resolve stage, the update sequencer and the BTB write port.
interface btb_update_ctrl_if #(
    parameter int unsigned PC_BITS    = 32,
    parameter int unsigned FIFO_DEPTH = 4
);
    localparam int unsigned CNT_BITS = $clog2(FIFO_DEPTH + 1);

    logic                upd_valid;
    logic [PC_BITS-1:0]  upd_orig_pc;
    logic [PC_BITS-1:0]  upd_target_pc;
    logic                upd_ready;
    logic                inv_valid;
    logic [PC_BITS-1:0]  inv_pc;
    logic                flush_req;
    logic                flush_busy;
    logic                flush_done;
    logic [CNT_BITS-1:0] fifo_count;
    logic                btb_wr_en;
    logic [PC_BITS-1:0]  btb_orig_pc;
    logic [PC_BITS-1:0]  btb_target_pc;
    logic                btb_invalidate;
    logic [PC_BITS-1:0]  btb_pc_invalid;

    modport master (
        output upd_valid, upd_orig_pc, upd_target_pc, inv_valid, inv_pc, flush_req,
        input  upd_ready, flush_busy, flush_done, fifo_count,
        input  btb_wr_en, btb_orig_pc, btb_target_pc, btb_invalidate, btb_pc_invalid
    );

    modport slave (
        input  upd_valid, upd_orig_pc, upd_target_pc, inv_valid, inv_pc, flush_req,
        output upd_ready, flush_busy, flush_done, fifo_count,
        output btb_wr_en, btb_orig_pc, btb_target_pc, btb_invalidate, btb_pc_invalid
    );
endinterface

// File: rtl/btb_update_ctrl.sv
// Buffers branch-resolution updates and sequences them, single-line invalidates and
// whole-table flush walks onto the BTB's one write/invalidate port pair.
module btb_update_ctrl #(
    parameter int unsigned PC_BITS    = 32,
    parameter int unsigned SIZE       = 1024,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    btb_update_ctrl_if.slave bus
);
    localparam int unsigned SEL_BITS = $clog2(SIZE);
    localparam int unsigned PTR_BITS = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_BITS = $clog2(FIFO_DEPTH + 1);

    typedef struct packed {
        logic [PC_BITS-1:0] orig;
        logic [PC_BITS-1:0] target;
    } upd_entry_t;

    typedef enum logic {IDLE = 1'b0, FLUSH = 1'b1} state_t;

    state_t              state;
    state_t              state_nxt;
    logic [SEL_BITS-1:0] flush_cnt;
    logic                flush_last;

    upd_entry_t          mem [FIFO_DEPTH];
    logic [PTR_BITS-1:0] wr_ptr;
    logic [PTR_BITS-1:0] rd_ptr;
    logic [CNT_BITS-1:0] count;
    upd_entry_t          head;
    logic                empty;
    logic                full;
    logic                push;
    logic                pop;
    logic                collide;

    logic                wr_en;
    logic                invalidate;
    logic [PC_BITS-1:0]  pc_invalid;
    logic                busy;
    logic                done;

    assign empty      = (count == '0);
    assign full       = (count == CNT_BITS'(FIFO_DEPTH));
    assign head       = mem[rd_ptr];
    assign push       = bus.upd_valid && !full;
    assign pop        = wr_en;
    assign flush_last = (flush_cnt == SEL_BITS'(SIZE - 1));

    // Same-line invalidate wins this cycle; the head write retries next cycle.
    assign collide = bus.inv_valid && !empty &&
                     (bus.inv_pc[SEL_BITS:1] == head.orig[SEL_BITS:1]);

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.flush_req) state_nxt = FLUSH;
            FLUSH:   if (flush_last)    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        wr_en      = 1'b0;
        invalidate = 1'b0;
        pc_invalid = '0;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: begin
                wr_en      = !empty && !collide;
                invalidate = bus.inv_valid;
                pc_invalid = bus.inv_pc;
            end
            FLUSH: begin
                busy       = 1'b1;
                invalidate = 1'b1;
                pc_invalid = PC_BITS'({flush_cnt, 1'b0});
                done       = flush_last;
            end
            default: ;
        endcase
    end

    // Walk index rests at zero while idle so each flush starts at line 0.
    always_ff @(posedge clk) begin
        if (rst || state == IDLE) flush_cnt <= '0;
        else                      flush_cnt <= flush_cnt + SEL_BITS'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_BITS'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_BITS'(1);
            case ({push, pop})
                2'b10:   count <= count + CNT_BITS'(1);
                2'b01:   count <= count - CNT_BITS'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= '{orig: bus.upd_orig_pc, target: bus.upd_target_pc};
    end

    assign bus.upd_ready      = !full;
    assign bus.fifo_count     = count;
    assign bus.flush_busy     = busy;
    assign bus.flush_done     = done;
    assign bus.btb_wr_en      = wr_en;
    assign bus.btb_orig_pc    = head.orig;
    assign bus.btb_target_pc  = head.target;
    assign bus.btb_invalidate = invalidate;
    assign bus.btb_pc_invalid = pc_invalid;
endmodule

// File: doc/btb_update_ctrl.md
Name: btb_update_ctrl

Overview:
Sequencer in front of the dual-read branch target buffer's single write/invalidate port pair. Buffers branch-resolution updates in a small FIFO and drains one per cycle. Passes single-line invalidations through, resolving same-line write/invalidate collisions. Runs a whole-table flush walk on request. Sits between the resolve/commit stage and the predictor's BTB.

Parameters:
PC_BITS, 32, PC address width
SIZE, 1024, BTB lines; SEL_BITS = $clog2(SIZE); line index = pc[SEL_BITS:1]
FIFO_DEPTH, 4, update buffer entries (power of 2, >=2)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
upd_valid  in  1  update request
upd_orig_pc  in  PC_BITS  branch PC
upd_target_pc  in  PC_BITS  resolved target
upd_ready  out  1  FIFO can accept (= !full)
inv_valid  in  1  single-line invalidate request
inv_pc  in  PC_BITS  PC whose line is invalidated
flush_req  in  1  invalidate whole table (pulse)
flush_busy  out  1  flush walk in progress
flush_done  out  1  1-cycle pulse on final flush invalidate
fifo_count  out  $clog2(FIFO_DEPTH+1)  occupancy
btb_wr_en  out  1  BTB write enable
btb_orig_pc  out  PC_BITS  BTB Orig_PC
btb_target_pc  out  PC_BITS  BTB Target_PC
btb_invalidate  out  1  BTB invalidate
btb_pc_invalid  out  PC_BITS  BTB pc_invalid

Behaviour:
- Reset (rst high at posedge): FIFO empty, fifo_count=0, state IDLE, flush counter 0, flush_done=0. upd_ready=1 after reset. All btb_* enables 0 while FIFO empty and IDLE.
- Enqueue: push when upd_valid && upd_ready. upd_ready depends only on the registered count. When full, no push even if a pop occurs the same cycle. No fall-through: earliest issue is the cycle after the push.
- Drain is combinational from the registered head:
  - btb_wr_en = !empty && state==IDLE && !collide.
  - btb_orig_pc / btb_target_pc = head fields. They may hold stale head data when btb_wr_en=0.
  - Pop when btb_wr_en=1. Maximum throughput is one write per cycle.
- External invalidate (IDLE only): btb_invalidate = inv_valid, btb_pc_invalid = inv_pc, with zero latency.
- Collision:
  - collide = inv_valid && !empty && inv_pc[SEL_BITS:1] == head orig_pc[SEL_BITS:1].
  - On collision the write is held and not popped. It issues the next cycle, unless collision repeats.
  - Net effect: invalidate lands first, then the update; the line ends valid with new data.
  - The BTB therefore never sees a same-line write+invalidate.
- Flush FSM, states IDLE and FLUSH:
  - IDLE->FLUSH on flush_req; counter cleared to 0.
  - In FLUSH: btb_invalidate=1, btb_pc_invalid = zero-extended {counter,1'b0}; counter increments each cycle.
  - When counter==SIZE-1: flush_done=1 and next state is IDLE.
  - flush_busy = (state==FLUSH).
  - Timing: flush_req at edge t gives invalidates on cycles t+1..t+SIZE, SIZE cycles exactly.
- During FLUSH:
  - FIFO writes are stalled, but pushes are still accepted up to full.
  - inv_valid is ignored and dropped: the walk covers every line and no writes occur during the walk.
  - flush_req is ignored.
- Simultaneous events in IDLE: flush_req with pending FIFO head, and/or inv_valid in the same cycle. Transition to FLUSH is registered, so the head write and the external invalidate still act this cycle under the collision rule.
- Reset mid-flush or with a non-empty FIFO: abort the walk and discard all queued updates. No btb_* enable in the following cycle.
- Ordering: FIFO is strictly in order. No coalescing of same-PC updates; the later one wins by write order.

Test Plan:
- Back-to-back push: after reset, 4 pushes (orig 0x100/0x104/0x108/0x10C) on consecutive cycles, FIFO_DEPTH=4 -> btb_wr_en high for 4 consecutive cycles starting the cycle after the first push, data in push order. upd_ready stays 1 because the count never reaches 4.
- Full: push 5 entries with no drain possible (held in FLUSH) -> upd_ready=0 at fifo_count=4, 5th not accepted. After flush ends, the 4 entries drain in order.
- Collision: head orig_pc=0x204 (line 0x102) with inv_valid, inv_pc=0x204 -> cycle N: btb_invalidate=1, btb_wr_en=0. Cycle N+1: btb_wr_en=1 with 0x204; fifo_count decrements only at N+1.
- No false collision: head 0x204, inv_pc=0x208 -> write and invalidate in the same cycle, head popped.
- Flush, SIZE=16: flush_req at cycle t -> btb_pc_invalid = 0x0, 0x2, …, 0x1E on cycles t+1..t+16. flush_done only at t+16, flush_busy low at t+17. A concurrent inv_valid is dropped, and a second flush_req at t+5 is ignored.
- Reset mid-flush at cycle t+7 with fifo_count=2 -> next cycle: state IDLE, fifo_count=0, btb_invalidate=0, btb_wr_en=0, upd_ready=1.
